// File: rtl/parking_pkg.sv
// Shared types, encodings and the cost helper for the parking slot arbiter.
package parking_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WR_ENTRY,
        S_RD,
        S_CALC,
        S_WR_COST,
        S_ACK
    } state_e;

    localparam logic OP_ENTER = 1'b0;
    localparam logic OP_EXIT  = 1'b1;

    localparam int DEF_NUM_REQ   = 2;
    localparam int DEF_NUM_SLOTS = 3;
    localparam int DEF_TW        = 10;
    localparam int DEF_RATE      = 1;

    // Elapsed time modulo 2^tw (timer wrap safe), scaled by rate at double
    // width, then clamped to the largest tw-bit value.
    function automatic logic [31:0] calc_cost(input logic [31:0] now,
                                              input logic [31:0] entry,
                                              input int          tw,
                                              input int          rate);
        logic [31:0] mask;
        logic [31:0] elapsed;
        logic [63:0] prod;
        mask    = (tw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << tw) - 32'd1);
        elapsed = (now - entry) & mask;
        prod    = {32'd0, elapsed} * {32'd0, 32'(rate)};
        if (prod > {32'd0, mask}) begin
            return mask;
        end
        return prod[31:0];
    endfunction

endpackage

// File: rtl/parking_rr_arbiter.sv
// Masked round-robin arbiter: one-hot grant, pointer moves past the winner.
// priority_mask_i, when it selects any eligible request, restricts the
// search to that class; round-robin order still applies inside it.
module parking_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] block_i,
    input  logic [NUM_REQ-1:0] priority_mask_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               any_o
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0] elig, pri, cand, one, shifted;
    logic               found;
    int                 idx;

    // Search candidates starting at the pointer; first hit wins.
    always_comb begin
        elig    = req_i & ~block_i;
        pri     = elig & priority_mask_i;
        cand    = (|pri) ? pri : elig;
        one     = NUM_REQ'(1);
        gnt_o   = '0;
        found   = 1'b0;
        ptr_d   = ptr_q;
        idx     = 0;
        shifted = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx     = (int'(ptr_q) + i) % NUM_REQ;
            shifted = cand >> idx;
            if (!found && shifted[0]) begin
                found = 1'b1;
                gnt_o = one << idx;
                ptr_d = PW'((idx + 1) % NUM_REQ);
            end
        end
        any_o = found;
    end

    // Pointer only moves when the grant is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (advance_i && found) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/parking_slot_arbiter.sv
// Parking slot arbiter: serialises gate enter/exit requests onto the single
// slot-memory path, validates them against the occupancy map and keeps the
// full/empty flags. Build option PARK_ARB_EXIT_PRIORITY_EN: exits win over
// enters during arbitration.
module parking_slot_arbiter
    import parking_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int TW        = DEF_TW,
    parameter int RATE      = DEF_RATE,
    localparam int SW       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_op,
    input  logic [NUM_REQ*SW-1:0] req_slot,
    output logic [NUM_REQ-1:0]    ack,
    output logic                  ack_ok,
    input  logic [TW-1:0]         timer_count,
    output logic [SW-1:0]         mem_sel,
    output logic                  mem_rd,
    input  logic [TW-1:0]         entry_time_out,
    output logic                  write_entry,
    output logic [TW-1:0]         entry_time_in,
    output logic                  write_cost,
    output logic [TW-1:0]         cost_in,
    output logic [NUM_SLOTS-1:0]  occupied,
    output logic                  full_flag,
    output logic                  empty_flag,
    output logic                  busy
);
    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   win_q, win_d, mask_q, gnt, pri_mask;
    logic                 op_q, op_d, ok_q, ok_d, any_req, advance;
    logic [SW-1:0]        slot_q, slot_d;
    logic [TW-1:0]        cost_q, cost_d;
    logic [NUM_SLOTS-1:0] occ_q, occ_d, sel_oh;
    logic                 full_q, empty_q, occ_hit, slot_ok;

`ifdef PARK_ARB_EXIT_PRIORITY_EN
    assign pri_mask = req_op;
`else
    assign pri_mask = '0;
`endif

    parking_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk             (clk),
        .rst_n           (reset),
        .req_i           (req),
        .block_i         (mask_q),
        .priority_mask_i (pri_mask),
        .advance_i       (advance),
        .gnt_o           (gnt),
        .any_o           (any_req)
    );

    // Slot decode and validity of the latched slot index.
    always_comb begin
        sel_oh = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            sel_oh[s] = (slot_q == SW'(s));
        end
        slot_ok = (int'(slot_q) < NUM_SLOTS);
        occ_hit = |(occ_q & sel_oh);
    end

    // Next-state, transaction latches and strobes.
    always_comb begin
        state_d       = state_q;
        win_d         = win_q;
        op_d          = op_q;
        slot_d        = slot_q;
        ok_d          = ok_q;
        cost_d        = cost_q;
        occ_d         = occ_q;
        advance       = 1'b0;
        ack           = '0;
        ack_ok        = 1'b0;
        mem_rd        = 1'b0;
        write_entry   = 1'b0;
        entry_time_in = '0;
        write_cost    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    advance = 1'b1;
                    win_d   = gnt;
                    op_d    = |(gnt & req_op);
                    for (int g = 0; g < NUM_REQ; g++) begin
                        if (gnt[g]) slot_d = req_slot[g*SW +: SW];
                    end
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!slot_ok || (op_q == OP_ENTER && occ_hit) ||
                    (op_q == OP_EXIT && !occ_hit)) begin
                    ok_d    = 1'b0;
                    state_d = S_ACK;
                end else begin
                    ok_d    = 1'b1;
                    state_d = (op_q == OP_ENTER) ? S_WR_ENTRY : S_RD;
                end
            end
            S_WR_ENTRY: begin
                write_entry   = 1'b1;
                entry_time_in = timer_count;
                occ_d         = occ_q | sel_oh;
                state_d       = S_ACK;
            end
            S_RD: begin
                mem_rd  = 1'b1;
                state_d = S_CALC;
            end
            S_CALC: begin
                cost_d  = TW'(calc_cost(32'(timer_count), 32'(entry_time_out), TW, RATE));
                state_d = S_WR_COST;
            end
            S_WR_COST: begin
                write_cost = 1'b1;
                occ_d      = occ_q & ~sel_oh;
                state_d    = S_ACK;
            end
            S_ACK: begin
                ack     = win_q;
                ack_ok  = ok_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_sel    = slot_q;
    assign cost_in    = cost_q;
    assign occupied   = occ_q;
    assign full_flag  = full_q;
    assign empty_flag = empty_q;
    assign busy       = (state_q != S_IDLE);

    // State, latched transaction, occupancy and flags; reset aborts everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            op_q    <= OP_ENTER;
            slot_q  <= '0;
            ok_q    <= 1'b0;
            cost_q  <= '0;
            occ_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            op_q    <= op_d;
            slot_q  <= slot_d;
            ok_q    <= ok_d;
            cost_q  <= cost_d;
            occ_q   <= occ_d;
            full_q  <= &occ_d;
            empty_q <= ~|occ_d;
            mask_q  <= ack;
        end
    end

endmodule

// File: doc/parking_slot_arbiter.md
# parking_slot_arbiter

Sequencer that shares the parking system's single slot-memory write path and cost datapath between multiple gate requesters. Accepts enter/exit requests, arbitrates round-robin, validates each against the per-slot occupancy map, and drives the memory read and write strobes and data for one transaction at a time. Sits between the gate-side request logic and the slot memory / timer in `parking_system_top`, and produces the full/empty flags.

## Interface
- `NUM_REQ`, 2: number of requesting gates
- `NUM_SLOTS`, 3: parking slots; slot index width `SW = $clog2(NUM_SLOTS)`
- `TW`, 10: timer, entry-time and cost width
- `RATE`, 1: cost units per timer tick
- `clk`  in  1: single clock, rising edge
- `reset`  in  1: asynchronous, active-low reset
- `req`  in  NUM_REQ: per-gate request; held high until the matching `ack`
- `req_op`  in  NUM_REQ: per-gate op, 0 = enter, 1 = exit
- `req_slot`  in  NUM_REQ*SW: per-gate slot index, packed, gate 0 in the LSBs
- `ack`  out  NUM_REQ: one-cycle completion pulse to the granted gate
- `ack_ok`  out  1: valid with `ack`; 1 = performed, 0 = rejected
- `timer_count`  in  TW: free-running time base
- `mem_sel`  out  SW: slot address for memory read and write
- `mem_rd`  out  1: read strobe; `entry_time_out` is valid the next cycle
- `entry_time_out`  in  TW: stored entry time of `mem_sel`
- `write_entry`  out  1: write-entry-time strobe, one cycle
- `entry_time_in`  out  TW: entry-time write data
- `write_cost`  out  1: write-cost strobe, one cycle
- `cost_in`  out  TW: cost write data
- `occupied`  out  NUM_SLOTS: occupancy map
- `full_flag`  out  1: all slots occupied
- `empty_flag`  out  1: no slot occupied
- `busy`  out  1: FSM not in IDLE

## Operation
- **FSM states:** IDLE, CHECK, WR_ENTRY, RD, CALC, WR_COST, ACK.
- **IDLE:** if any eligible `req` is high, latch the winner's index, op and slot, then go to CHECK.
  - Arbitration is round-robin. The pointer advances to winner+1 when the request is granted.
  - The gate acked in the previous cycle is masked for one cycle, so a held request is not serviced twice.
- **CHECK:**
  - Reject (go to ACK with `ack_ok`=0) if the slot index is ≥ NUM_SLOTS, if it is an enter to an occupied slot, or if it is an exit from a free slot.
  - Otherwise an enter goes to WR_ENTRY and an exit goes to RD.
- **WR_ENTRY:** `write_entry`=1, `entry_time_in`=`timer_count`; set `occupied[slot]`; go to ACK.
- **RD:** `mem_rd`=1; go to CALC.
- **CALC:** register the cost from `entry_time_out`; go to WR_COST.
  - `elapsed = (timer_count − entry_time_out) mod 2^TW`, which handles timer wrap.
  - `cost = elapsed*RATE` computed at 2*TW bits, then saturated to 2^TW−1.
- **WR_COST:** `write_cost`=1, `cost_in`=registered cost; clear `occupied[slot]`; go to ACK.
- **ACK:** `ack[winner]`=1 and `ack_ok` driven for one cycle; go to IDLE.
- **Flags:** `full_flag` = &`occupied`, `empty_flag` = ~|`occupied`; both are registered from the next-state map, so they update together with `occupied`.
- **Simultaneous requests:** only one transaction is in flight; other requesters wait with `req` held.
- **`mem_sel`:** holds the latched slot from CHECK through ACK.

## Timing
- **Reset values:**
  - `ack`=0, `ack_ok`=0, `mem_rd`=0, `write_entry`=0, `write_cost`=0
  - `mem_sel`=0, `entry_time_in`=0, `cost_in`=0, `occupied`=0
  - `full_flag`=0, `empty_flag`=1, `busy`=0; FSM in IDLE, RR pointer 0
- **Enter latency:** request seen in IDLE at cycle 0 → `write_entry` at cycle 2 → `ack` at cycle 3.
- **Exit latency:** `mem_rd` at cycle 2 → `write_cost` at cycle 4 → `ack` at cycle 5.
- **Reject:** `ack` with `ack_ok`=0 at cycle 2; memory is untouched.
- **Reset mid-transaction:** the transaction is aborted immediately; no strobe completes and no ack is issued. The requester re-requests after reset.
- **`req` dropped before `ack`:** this is a protocol violation. The transaction still completes and the `ack` is still issued.

## Configuration
- **`PARK_ARB_EXIT_PRIORITY_EN` defined:** among eligible requests, exits beat enters. Round-robin applies within each class, so a departing car frees its slot before a competing entry is checked.
- **Undefined:** pure round-robin regardless of op.

## Structure
- **Package `parking_pkg`:**
  - FSM state enum
  - op encoding `OP_ENTER`/`OP_EXIT`
  - saturating cost function `calc_cost(now, entry)`
  - default width constants
- **Sub-module `parking_rr_arbiter`:** masked round-robin grant, one-hot output, pointer register. It exposes a `priority_mask` input used by the exit-priority option.

## Test plan
- Gate 0 enter slot 1 at timer 20 → `write_entry` cycle 2 with `entry_time_in`=20; `ack[0]`, `ack_ok`=1 cycle 3; `occupied`=3'b010, `empty_flag`=0.
- Enter slots 0, 1 and 2, then enter slot 0 again → third write sets `full_flag`=1; the fourth request gets `ack_ok`=0, no strobe, `full_flag` stays 1.
- Exit from slot 1 entered at 1020 when timer = 5 (wrap), RATE=1 → `mem_rd` cycle 2; `cost_in`=9 with `write_cost` cycle 4; slot cleared; `full_flag`=0.
- Gates 0 and 1 request in the same cycle, both held → gate 0 served first, then gate 1. With `PARK_ARB_EXIT_PRIORITY_EN` and gate 1 = exit, gate 1 is served first.
- Exit from a free slot, and a slot index of 3 → both get `ack_ok`=0 at cycle 2, no `mem_rd`/write strobes.
- `reset` low during RD of an exit → all outputs take their reset values within the same cycle; no `write_cost`, no `ack`; `occupied`=0, `empty_flag`=1.
